// File: rtl/seqdet_arb.sv
// seqdet_arb: round-robin sequencer sharing one serial pattern detector among
// NREQ frame sources; streams the granted frame MSB-first and counts hits.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   req        in   [NREQ]          per-requester request
//   frame_data in   [NREQ*FRAME_W]  requester i frame at [i*FRAME_W +: FRAME_W]
//   gnt        out  [NREQ]          registered one-hot grant
//   det_x      out  serial bit to detector
//   det_rst    out  detector reset, active-low
//   det_z      in   detector hit flag (combinational from det_x)
//   done       out  one-cycle frame-finished pulse
//   done_id    out  [ID_W]   reported requester id
//   hit_cnt    out  [CNT_W]  saturating hit count for the frame
//
// Build option: define SEQDET_ARB_FIXED_PRIO_EN for fixed-priority arbitration
// (lowest index wins, no round-robin pointer). Default is round-robin.

module seqdet_arb #(
  parameter int NREQ    = 4,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*FRAME_W-1:0]   frame_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      det_x,
  output logic                      det_rst,
  input  logic                      det_z,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [CNT_W-1:0]          hit_cnt
);

  localparam int BC_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_W - 1);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NREQ - 1);
  localparam logic [NREQ-1:0] GNT0     = NREQ'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_REPORT
  } state_t;

  state_t               r_state;
  logic [NREQ-1:0]      r_gnt;
  logic [FRAME_W-1:0]   r_shift;
  logic [ID_W-1:0]      r_id;
  logic [BC_W-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]     r_acc;
  logic                 r_done;
  logic [ID_W-1:0]      r_done_id;
  logic [CNT_W-1:0]     r_hit_cnt;

  logic [ID_W-1:0]      w_pick_id;
  logic [FRAME_W-1:0]   w_frame;
  logic [CNT_W-1:0]     w_acc_nxt;

`ifndef SEQDET_ARB_FIXED_PRIO_EN
  localparam int REQ_W = 1 << ID_W;
  localparam logic [ID_W:0] NREQ_X = (ID_W+1)'(NREQ);

  logic [ID_W-1:0]      r_rr_ptr;
  logic [REQ_W-1:0]     w_req_ext;
  logic [ID_W:0]        w_idx;
  logic                 w_found;

  // Widened so any ID_W-bit index stays in range.
  assign w_req_ext = REQ_W'(req);

  // Scan upward from the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found   = 1'b0;
    w_pick_id = '0;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= NREQ_X) w_idx = w_idx - NREQ_X;
      if (!w_found && w_req_ext[w_idx[ID_W-1:0]]) begin
        w_found   = 1'b1;
        w_pick_id = w_idx[ID_W-1:0];
      end
    end
  end
`else
  // Downward scan so the lowest set index is the last one written.
  always_comb begin
    w_pick_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) w_pick_id = ID_W'(k);
    end
  end
`endif

  always_comb begin
    w_frame = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_pick_id == ID_W'(k))
        w_frame = frame_data[k*FRAME_W +: FRAME_W];
    end
  end

  // det_z refers to the bit currently on det_x, so fold it in this cycle.
  always_comb begin
    w_acc_nxt = r_acc;
    if (det_z && (r_acc != CNT_MAX))
      w_acc_nxt = r_acc + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_shift   <= '0;
      r_id      <= '0;
      r_bit_cnt <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_hit_cnt <= '0;
`ifndef SEQDET_ARB_FIXED_PRIO_EN
      r_rr_ptr  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt   <= GNT0 << w_pick_id;
            r_shift <= w_frame;
            r_id    <= w_pick_id;
            r_state <= S_CLR;
          end
        end
        S_CLR: begin
          r_bit_cnt <= '0;
          r_acc     <= '0;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          r_shift   <= r_shift << 1;
          r_acc     <= w_acc_nxt;
          r_bit_cnt <= r_bit_cnt + BC_W'(1);
          if (r_bit_cnt == LAST_BIT) begin
            r_state   <= S_REPORT;
            r_done    <= 1'b1;
            r_done_id <= r_id;
            r_hit_cnt <= w_acc_nxt;
            r_gnt     <= '0;
`ifndef SEQDET_ARB_FIXED_PRIO_EN
            r_rr_ptr  <= (r_id == LAST_ID) ? '0 : r_id + ID_W'(1);
`endif
          end
        end
        S_REPORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign hit_cnt = r_hit_cnt;

  // Detector is held in reset during CLR and while our own reset is low.
  assign det_rst = rst & (r_state != S_CLR);
  assign det_x   = (r_state == S_SHIFT) & r_shift[FRAME_W-1];

endmodule
